bcd_display_scanner: RTL and testbench

- Downstream consumer of the decade counter chain. Takes DIGITS packed BCD digits (one 0..9 count per counter stage) and drives a time-multiplexed, common-anode-select seven-segment display.
- A prescaler sets the digit refresh rate. The digit values are snapshotted at each frame boundary so that a counter update mid-frame never tears the display.
- Leading zeros are blanked.

---
 rtl/bcd_display_scanner_pkg.sv | 20 ++
 rtl/bcd_display_scanner_seg7_decode.sv | 26 ++
 rtl/bcd_display_scanner.sv | 99 +++++++++
 tb/tb_bcd_display_scanner.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the multiplexed BCD seven-segment scanner.
// Segment codes are active-high, bit0=a .. bit6=g.
package bcd_display_scanner_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scanner_seg7_decode.sv
// BCD to seven-segment decoder; non-decimal codes 10..15 show a dash.
module seg7_decode
  import bcd_display_scanner_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame digit snapshot
// and leading-zero blanking.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [BCD_W*DIGITS-1:0]   io_digits,
  input  logic [DIGITS-1:0]         io_dp,
  output logic [6:0]                io_seg,
  output logic                      io_dp_out,
  output logic [DIGITS-1:0]         io_an,
  output logic                      io_frame
);

  localparam int unsigned TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BCD_W*DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [DIGITS-1:0]       snap_dp_q, snap_dp_d;

  logic                    tick, frame_end;
  logic [DIGITS-1:0]       zero_from;
  logic [BCD_W-1:0]        cur_digit;
  logic                    cur_dp, cur_blank;
  logic [6:0]              dec_seg;

  assign tick      = (tick_cnt_q == TICK_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);

  always_comb begin
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      snap_digits_d = io_digits;
      snap_dp_d     = io_dp;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
    end
  end

  // zero_from[k] is set when snapshot digits k..DIGITS-1 are all zero
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (snap_digits_q[BCD_W*DIGITS-1 -: BCD_W] == '0);
    for (int unsigned k = DIGITS - 1; k > 0; k--) begin
      zero_from[k-1] = zero_from[k] && (snap_digits_q[(k-1)*BCD_W +: BCD_W] == '0);
    end
  end

  always_comb begin
    io_an     = '0;
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        io_an[k]  = 1'b1;
        cur_digit = snap_digits_q[k*BCD_W +: BCD_W];
        cur_dp    = snap_dp_q[k];
        cur_blank = (k != 0) && zero_from[k];
      end
    end
  end

  seg7_decode u_decode (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  assign io_seg    = cur_blank ? SEG_BLANK : dec_seg;
  assign io_dp_out = cur_dp;
  assign io_frame  = frame_end;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGITS=4, REFRESH_DIV=4.
module tb_bcd_display_scanner;

  logic        clock;
  logic        reset;
  logic [15:0] io_digits;
  logic [3:0]  io_dp;
  logic [6:0]  io_seg;
  logic        io_dp_out;
  logic [3:0]  io_an;
  logic        io_frame;

  int checks   = 0;
  int failures = 0;

  bcd_display_scanner #(
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_digits (io_digits),
    .io_dp     (io_dp),
    .io_seg    (io_seg),
    .io_dp_out (io_dp_out),
    .io_an     (io_an),
    .io_frame  (io_frame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Checks the current cycle (sampled at negedge) then advances one cycle.
  task automatic expect_cycle(input string tag, input logic [3:0] an, input logic [6:0] seg,
                              input logic dp, input logic fr);
    check_eq({tag, ".an"},    16'(io_an),     16'(an));
    check_eq({tag, ".seg"},   16'(io_seg),    16'(seg));
    check_eq({tag, ".dp"},    16'(io_dp_out), 16'(dp));
    check_eq({tag, ".frame"}, 16'(io_frame),  16'(fr));
    @(negedge clock);
  endtask

  task automatic expect_slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input logic last);
    for (int c = 0; c < 4; c++) begin
      expect_cycle(tag, an, seg, dp, last && (c == 3));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic skip_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    io_digits = 16'h0000;
    io_dp     = 4'b0000;

    // 1: reset values, blanking of digit 1, frame pulse only at cycle 15
    do_reset();
    expect_slot("t1.d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    expect_slot("t1.d1", 4'b0010, 7'h00, 1'b0, 1'b0);
    expect_slot("t1.d2", 4'b0100, 7'h00, 1'b0, 1'b0);
    expect_slot("t1.d3", 4'b1000, 7'h00, 1'b0, 1'b1);
    expect_cycle("t1.c16", 4'b0001, 7'h3F, 1'b0, 1'b0);

    // 2: scan order; first frame still shows the cleared snapshot
    io_digits = 16'h1234;
    do_reset();
    expect_slot("t2.f1d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    expect_slot("t2.f1d1", 4'b0010, 7'h00, 1'b0, 1'b0);
    expect_slot("t2.f1d2", 4'b0100, 7'h00, 1'b0, 1'b0);
    expect_slot("t2.f1d3", 4'b1000, 7'h00, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      expect_slot("t2.d0", 4'b0001, 7'h66, 1'b0, 1'b0);
      expect_slot("t2.d1", 4'b0010, 7'h4F, 1'b0, 1'b0);
      expect_slot("t2.d2", 4'b0100, 7'h5B, 1'b0, 1'b0);
      expect_slot("t2.d3", 4'b1000, 7'h06, 1'b0, 1'b1);
    end

    // 3: leading-zero blanking with an embedded zero on digit 0
    io_digits = 16'h0070;
    do_reset();
    skip_cycles(16);
    expect_slot("t3.d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    expect_slot("t3.d1", 4'b0010, 7'h07, 1'b0, 1'b0);
    expect_slot("t3.d2", 4'b0100, 7'h00, 1'b0, 1'b0);
    expect_slot("t3.d3", 4'b1000, 7'h00, 1'b0, 1'b1);

    // 4: illegal BCD dash, dp survives blanking
    io_digits = 16'h00F0;
    io_dp     = 4'b0100;
    do_reset();
    skip_cycles(16);
    expect_slot("t4.d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    expect_slot("t4.d1", 4'b0010, 7'h40, 1'b0, 1'b0);
    expect_slot("t4.d2", 4'b0100, 7'h00, 1'b1, 1'b0);
    expect_slot("t4.d3", 4'b1000, 7'h00, 1'b0, 1'b1);

    // 5: mid-frame input change must not tear the display
    io_digits = 16'h5678;
    io_dp     = 4'b0000;
    do_reset();
    skip_cycles(16);
    expect_slot("t5.d0", 4'b0001, 7'h7F, 1'b0, 1'b0);
    io_digits = 16'h9999;
    expect_slot("t5.d1", 4'b0010, 7'h07, 1'b0, 1'b0);
    expect_slot("t5.d2", 4'b0100, 7'h7D, 1'b0, 1'b0);
    expect_slot("t5.d3", 4'b1000, 7'h6D, 1'b0, 1'b1);
    expect_slot("t5.n0", 4'b0001, 7'h6F, 1'b0, 1'b0);
    expect_slot("t5.n1", 4'b0010, 7'h6F, 1'b0, 1'b0);
    expect_slot("t5.n2", 4'b0100, 7'h6F, 1'b0, 1'b0);
    expect_slot("t5.n3", 4'b1000, 7'h6F, 1'b0, 1'b1);

    // 6: one-cycle reset while idx=2 abandons the frame and clears the snapshot
    io_digits = 16'h1234;
    io_dp     = 4'b1111;
    do_reset();
    skip_cycles(16);
    expect_slot("t6.d0", 4'b0001, 7'h66, 1'b1, 1'b0);
    expect_slot("t6.d1", 4'b0010, 7'h4F, 1'b1, 1'b0);
    expect_cycle("t6.d2", 4'b0100, 7'h5B, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expect_slot("t6.r0", 4'b0001, 7'h3F, 1'b0, 1'b0);
    expect_slot("t6.r1", 4'b0010, 7'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
